// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one 8-bit UART transmitter between NUM_REQ byte producers.
// Sequences each byte: accept, hold tx_enable until busy is seen, then wait for busy to fall.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned START_TIMEOUT = 65536,
  parameter int unsigned SYNC_STAGES   = 2,
  localparam int unsigned ID_W         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   tx_enable,
  output logic [7:0]             tx_data,
  input  logic                   tx_busy,
  output logic [ID_W-1:0]        grant_id,
  output logic                   tx_done,
  output logic                   tx_timeout,
  output logic                   ctrl_busy
);

  localparam int unsigned CNT_W = $clog2(START_TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LAUNCH    = 2'd1,
    S_WAIT_DONE = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [SYNC_STAGES-1:0] r_busy_sync;
  logic                   w_busy_s;
  logic [ID_W-1:0]        r_ptr;
  logic [ID_W-1:0]        w_ptr_nxt;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic                   r_tx_enable;
  logic                   w_tx_enable_nxt;
  logic [7:0]             r_tx_data;
  logic [7:0]             w_tx_data_nxt;
  logic [ID_W-1:0]        r_grant;
  logic [ID_W-1:0]        w_grant_nxt;
  logic                   r_tx_done;
  logic                   w_tx_done_nxt;
  logic                   r_tx_timeout;
  logic                   w_tx_timeout_nxt;
  logic                   r_ctrl_busy;
  logic                   w_found;
  logic [ID_W-1:0]        w_winner;
  logic                   w_grant_now;

  // tx_busy arrives from the baud domain
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_busy_sync <= '0;
    else       r_busy_sync <= {r_busy_sync[SYNC_STAGES-2:0], tx_busy};
  end

  assign w_busy_s = r_busy_sync[SYNC_STAGES-1];

  // First valid requester after the pointer, wrapping around
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      if (!w_found && req_valid[(32'(r_ptr) + k) % NUM_REQ]) begin
        w_found  = 1'b1;
        w_winner = ID_W'((32'(r_ptr) + k) % NUM_REQ);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_ptr_nxt        = r_ptr;
    w_cnt_nxt        = r_cnt;
    w_tx_enable_nxt  = r_tx_enable;
    w_tx_data_nxt    = r_tx_data;
    w_grant_nxt      = r_grant;
    w_tx_done_nxt    = 1'b0;
    w_tx_timeout_nxt = 1'b0;
    w_grant_now      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found && !w_busy_s) begin
          w_grant_now     = 1'b1;
          w_tx_data_nxt   = req_data[8*32'(w_winner) +: 8];
          w_grant_nxt     = w_winner;
          w_tx_enable_nxt = 1'b1;
          w_cnt_nxt       = '0;
          w_state_nxt     = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        // busy takes precedence over the watchdog on the same cycle
        if (w_busy_s) begin
          w_tx_enable_nxt = 1'b0;
          w_state_nxt     = S_WAIT_DONE;
        end else if (r_cnt == CNT_W'(START_TIMEOUT - 1)) begin
          w_tx_enable_nxt  = 1'b0;
          w_tx_timeout_nxt = 1'b1;
          w_ptr_nxt        = r_grant;
          w_state_nxt      = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_WAIT_DONE: begin
        if (!w_busy_s) begin
          w_tx_done_nxt = 1'b1;
          w_ptr_nxt     = r_grant;
          w_state_nxt   = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = w_grant_now && (w_winner == ID_W'(i));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr        <= ID_W'(NUM_REQ - 1);
      r_cnt        <= '0;
      r_tx_enable  <= 1'b0;
      r_tx_data    <= '0;
      r_grant      <= '0;
      r_tx_done    <= 1'b0;
      r_tx_timeout <= 1'b0;
      r_ctrl_busy  <= 1'b0;
    end else begin
      r_ptr        <= w_ptr_nxt;
      r_cnt        <= w_cnt_nxt;
      r_tx_enable  <= w_tx_enable_nxt;
      r_tx_data    <= w_tx_data_nxt;
      r_grant      <= w_grant_nxt;
      r_tx_done    <= w_tx_done_nxt;
      r_tx_timeout <= w_tx_timeout_nxt;
      r_ctrl_busy  <= (w_state_nxt != S_IDLE);
    end
  end

  assign tx_enable  = r_tx_enable;
  assign tx_data    = r_tx_data;
  assign grant_id   = r_grant;
  assign tx_done    = r_tx_done;
  assign tx_timeout = r_tx_timeout;
  assign ctrl_busy  = r_ctrl_busy;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: directed stimulus queues expected grants and
// completions; a negedge monitor pops and compares as the DUT produces them.
module tb_uart_tx_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned TO = 8;
  localparam int unsigned SS = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic [NR-1:0]  req_valid;
  logic [8*NR-1:0] req_data;
  logic [NR-1:0]  req_ready;
  logic           tx_enable;
  logic [7:0]     tx_data;
  logic           tx_busy;
  logic [1:0]     grant_id;
  logic           tx_done;
  logic           tx_timeout;
  logic           ctrl_busy;

  typedef struct {
    int         id;
    logic [7:0] data;
  } grant_t;

  grant_t gq[$];
  int     eq[$];
  int     n_vec    = 0;
  int     n_err    = 0;
  int     n_ready  = 0;
  int     n_ready1 = 0;
  bit     xmit_auto = 1'b0;
  logic [NR-1:0] prev_ready = '0;
  logic   prev_en = 1'b0;

  uart_tx_arbiter #(.NUM_REQ(NR), .START_TIMEOUT(TO), .SYNC_STAGES(SS)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tx_enable(tx_enable), .tx_data(tx_data),
    .tx_busy(tx_busy), .grant_id(grant_id), .tx_done(tx_done),
    .tx_timeout(tx_timeout), .ctrl_busy(ctrl_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: wait timed out", name);
  endtask

  // Scoreboard monitor
  initial begin
    grant_t g;
    int k;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (req_ready != '0) begin
          n_ready++;
          if (req_ready[1]) n_ready1++;
          check("ready_onehot", 32'($countones(req_ready)), 32'd1);
        end
        if (tx_enable && !prev_en) begin
          if (gq.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_grant: got id %0d expected none", grant_id);
          end else begin
            g = gq.pop_front();
            check("grant_id", 32'(grant_id), 32'(g.id));
            check("tx_data", 32'(tx_data), 32'(g.data));
            check("ready_of_grant", 32'(prev_ready), 32'(1) << g.id);
          end
        end
        if (tx_done || tx_timeout) begin
          check("done_xor_timeout", 32'(tx_done & tx_timeout), 32'd0);
          if (eq.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_end: got done=%0b timeout=%0b expected none", tx_done, tx_timeout);
          end else begin
            k = eq.pop_front();
            check("end_is_timeout", 32'(tx_timeout), 32'(k));
          end
        end
      end
      prev_en    = tx_enable;
      prev_ready = req_ready;
    end
  end

  // Transmitter model: busy rises 3 cycles after enable is seen, held 10 cycles
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (xmit_auto && tx_enable && !tx_busy && !reset) begin
        repeat (3) @(posedge clk);
        #1 tx_busy = 1'b1;
        repeat (10) @(posedge clk);
        #1 tx_busy = 1'b0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
  endtask

  task automatic wait_ready(input int target, input string name);
    int c = 0;
    while (n_ready < target && c < 400) begin
      tick(1);
      c++;
    end
    if (n_ready < target) flag(name);
  endtask

  task automatic wait_idle(input string name);
    int c = 0;
    while ((ctrl_busy || tx_busy) && c < 400) begin
      tick(1);
      c++;
    end
    if (ctrl_busy || tx_busy) flag(name);
    tick(2);
  endtask

  task automatic wait_en_fall(input string name, output int hi);
    int c = 0;
    hi = 0;
    while (!tx_enable && c < 100) begin
      tick(1);
      c++;
    end
    while (tx_enable && hi < 100) begin
      hi++;
      tick(1);
    end
    if (c >= 100 || hi >= 100) flag(name);
  endtask

  initial begin
    int base;
    int r1base;
    int hi;
    int c;
    reset     = 1'b1;
    req_valid = '0;
    req_data  = '0;
    #2;
    check("rst_tx_enable", 32'(tx_enable), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    check("rst_tx_done", 32'(tx_done), 32'd0);
    check("rst_tx_timeout", 32'(tx_timeout), 32'd0);
    check("rst_ctrl_busy", 32'(ctrl_busy), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);

    // Single byte
    do_reset();
    xmit_auto = 1'b1;
    req_data[7:0] = 8'hA5;
    gq.push_back('{0, 8'hA5});
    eq.push_back(0);
    base = n_ready;
    req_valid = 4'b0001;
    wait_ready(base + 1, "t1_ready");
    req_valid = '0;
    wait_en_fall("t1_enable", hi);
    check("t1_busy_at_enable_drop", 32'(tx_busy), 32'd1);
    wait_idle("t1_idle");
    check("t1_grant_id_hold", 32'(grant_id), 32'd0);
    check("t1_tx_data_hold", 32'(tx_data), 32'hA5);

    // Fairness with all four requesters valid
    do_reset();
    req_data = {8'h13, 8'h12, 8'h11, 8'h10};
    for (int i = 0; i < 6; i++) begin
      gq.push_back('{i % 4, 8'(8'h10 + i % 4)});
      eq.push_back(0);
    end
    base = n_ready;
    req_valid = 4'b1111;
    wait_ready(base + 6, "t2_ready");
    req_valid = '0;
    wait_idle("t2_idle");
    check("t2_ready_count", 32'(n_ready - base), 32'd6);

    // Watchdog with transmitter never starting
    do_reset();
    xmit_auto = 1'b0;
    req_data[15:0] = {8'h32, 8'h31};
    gq.push_back('{0, 8'h31});
    gq.push_back('{1, 8'h32});
    eq.push_back(1);
    eq.push_back(1);
    base = n_ready;
    req_valid = 4'b0011;
    wait_en_fall("t3_enable", hi);
    check("t3_enable_cycles", 32'(hi), 32'(TO));
    wait_ready(base + 2, "t3_ready");
    req_valid = '0;
    wait_idle("t3_idle");
    check("t3_second_grant_id", 32'(grant_id), 32'd1);

    // Stale busy blocks grant until synchronized low
    do_reset();
    tx_busy = 1'b1;
    tick(3);
    req_data[23:16] = 8'h77;
    req_valid = 4'b0100;
    for (int i = 0; i < 5; i++) begin
      check("t4_no_ready_while_busy", 32'(req_ready), 32'd0);
      tick(1);
    end
    gq.push_back('{2, 8'h77});
    eq.push_back(0);
    tx_busy = 1'b0;
    xmit_auto = 1'b1;
    c = 0;
    while (req_ready == '0 && c < 20) begin
      tick(1);
      c++;
    end
    check("t4_grant_latency", 32'(c), 32'(SS));
    tick(1);
    req_valid = '0;
    wait_idle("t4_idle");

    // Reset during WAIT_DONE
    do_reset();
    req_data[7:0] = 8'h3C;
    gq.push_back('{0, 8'h3C});
    base = n_ready;
    req_valid = 4'b0001;
    wait_ready(base + 1, "t5_ready");
    req_valid = '0;
    wait_en_fall("t5_enable", hi);
    #2 reset = 1'b1;
    #1;
    check("t5_async_tx_enable", 32'(tx_enable), 32'd0);
    check("t5_async_tx_data", 32'(tx_data), 32'd0);
    check("t5_async_grant_id", 32'(grant_id), 32'd0);
    check("t5_async_ctrl_busy", 32'(ctrl_busy), 32'd0);
    check("t5_async_tx_done", 32'(tx_done), 32'd0);
    check("t5_async_tx_timeout", 32'(tx_timeout), 32'd0);
    c = 0;
    while (tx_busy && c < 50) begin
      tick(1);
      c++;
    end
    tick(2);
    req_data[15:0] = {8'h02, 8'h01};
    gq.push_back('{0, 8'h01});
    gq.push_back('{1, 8'h02});
    eq.push_back(0);
    eq.push_back(0);
    base = n_ready;
    req_valid = 4'b0011;
    reset = 1'b0;
    wait_ready(base + 1, "t5_ready_a");
    req_valid[0] = 1'b0;
    wait_ready(base + 2, "t5_ready_b");
    req_valid = '0;
    wait_idle("t5_idle");

    // Valid pulse outside IDLE is ignored
    do_reset();
    req_data[15:0] = {8'h99, 8'h55};
    gq.push_back('{0, 8'h55});
    eq.push_back(0);
    base = n_ready;
    r1base = n_ready1;
    req_valid = 4'b0001;
    wait_ready(base + 1, "t6_ready");
    req_valid = '0;
    wait_en_fall("t6_enable", hi);
    tick(1);
    req_valid[1] = 1'b1;
    tick(1);
    req_valid[1] = 1'b0;
    wait_idle("t6_idle");
    tick(5);
    check("t6_req1_grants", 32'(n_ready1 - r1base), 32'd0);

    check("grant_queue_empty", 32'(gq.size()), 32'd0);
    check("end_queue_empty", 32'(eq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
